// File: rtl/seq_partial_mult_if.sv
// Operand/product channel of the sequential multiplier.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
// the sender holds its payload stable while valid=1 and ready=0.
interface seq_partial_mult_if #(
   parameter int WIDTH = 16
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] product;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product
   );
endinterface

// File: rtl/seq_partial_mult.sv
// Multi-cycle unsigned multiplier: reduces BPC partial-product rows per clock
// into a 2*WIDTH accumulator; the result is held until consumed.
module seq_partial_mult #(
   parameter int WIDTH = 16,
   parameter int BPC   = 4
) (
   input  logic              clk,
   input  logic              reset,
   seq_partial_mult_if.slave bus,
   output logic [1:0]        dbg_state
);
   localparam int NSTEPS = WIDTH / BPC;
   localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSTEPS - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   generate
      if (WIDTH % BPC != 0) begin : g_bad_bpc
         $error("seq_partial_mult: WIDTH must be a multiple of BPC");
      end
   endgenerate

   logic [1:0]         state;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [2*WIDTH-1:0] product_r;
   logic [CW-1:0]      count;
   logic               in_ready_r;
   logic               out_valid_r;
   logic [WIDTH-1:0]   b_slice;
   logic [2*WIDTH-1:0] a_base;

   // The BPC rows for the current multiplier slice are summed into acc in one cycle.
   always_comb begin
      b_slice  = b_r >> (int'(count) * BPC);
      a_base   = {{WIDTH{1'b0}}, a_r} << (int'(count) * BPC);
      acc_next = acc;
      for (int j = 0; j < BPC; j++) begin
         if (b_slice[j]) acc_next = acc_next + (a_base << j);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         a_r         <= '0;
         b_r         <= '0;
         acc         <= '0;
         count       <= '0;
         product_r   <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_r        <= bus.a;
                  b_r        <= bus.b;
                  acc        <= '0;
                  count      <= '0;
                  state      <= CALC;
                  in_ready_r <= 1'b0;
               end
            end
            CALC: begin
               acc   <= acc_next;
               count <= count + 1'b1;
               if (count == LAST) begin
                  product_r   <= acc_next;
                  state       <= DONE;
                  out_valid_r <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.product   = product_r;
   assign dbg_state     = state;
endmodule
